// File: rtl/demo_seq_pkg.sv
// Shared definitions for the demo scene sequencer and the per-scene pixel
// generators that decode the fade level.
package demo_seq_pkg;

  // Sequencer phase for one scene
  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    SHOW     = 2'd1,
    FADE_OUT = 2'd2
  } seq_state_t;

  // Full brightness for the default 4-bit fade; its width sets the default FADE_W
  localparam logic [3:0] FADE_MAX = '1;

  // Free-running animation frame counter width
  localparam int unsigned FRAME_CNT_W = 16;

  // Width of the per-scene SHOW frame counter
  localparam int unsigned SCENE_FRAME_W = 10;

endpackage

// File: rtl/demo_scene_sequencer_btn_sync.sv
// Two-flop synchroniser for raw button/switch levels, with a one-cycle
// rising-edge pulse derived from the synchronised level.
module btn_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene scheduler: counts frames, selects the active scene and
// ramps a fade level FADE_IN -> SHOW -> FADE_OUT for each scene.
module demo_scene_sequencer
  import demo_seq_pkg::*;
#(
  parameter int unsigned NUM_SCENES   = 4,
  parameter int unsigned SCENE_W      = 2,
  parameter int unsigned SCENE_FRAMES = 240,
  parameter int unsigned FADE_W       = $bits(FADE_MAX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     pause,
  input  logic                     skip,
  input  logic                     sel_en,
  input  logic [SCENE_W-1:0]       sel,
  output logic [SCENE_W-1:0]       scene_id,
  output logic [FADE_W-1:0]        fade,
  output logic [SCENE_FRAME_W-1:0] scene_frame,
  output logic [FRAME_CNT_W-1:0]   frame_count,
  output logic                     in_transition
);

  localparam logic [SCENE_W-1:0]       LAST_SCENE = SCENE_W'(NUM_SCENES - 1);
  localparam logic [SCENE_W:0]         SCENE_LIM  = (SCENE_W + 1)'(NUM_SCENES);
  localparam logic [SCENE_FRAME_W-1:0] LAST_FRAME = SCENE_FRAME_W'(SCENE_FRAMES - 1);
  localparam logic [FADE_W-1:0]        FADE_FULL  = '1;

  // Synchronised controls
  logic               pause_s;
  logic               sel_en_s;
  logic [SCENE_W-1:0] sel_s;
  logic               skip_rise;
  logic               unused_pause_rise;
  logic               unused_sel_en_rise;
  logic [SCENE_W-1:0] unused_sel_rise;
  logic               unused_skip_sync;

  btn_sync_edge #(.W(1)) u_sync_pause (
    .clk(clk), .rst_n(rst_n), .din(pause), .sync(pause_s), .rise(unused_pause_rise)
  );
  btn_sync_edge #(.W(1)) u_sync_skip (
    .clk(clk), .rst_n(rst_n), .din(skip), .sync(unused_skip_sync), .rise(skip_rise)
  );
  btn_sync_edge #(.W(1)) u_sync_sel_en (
    .clk(clk), .rst_n(rst_n), .din(sel_en), .sync(sel_en_s), .rise(unused_sel_en_rise)
  );
  btn_sync_edge #(.W(SCENE_W)) u_sync_sel (
    .clk(clk), .rst_n(rst_n), .din(sel), .sync(sel_s), .rise(unused_sel_rise)
  );

  seq_state_t                 state_q, state_d;
  logic [SCENE_W-1:0]         scene_id_q, scene_id_d;
  logic [SCENE_W-1:0]         next_q, next_d;
  logic [FADE_W-1:0]          fade_q, fade_d;
  logic [SCENE_FRAME_W-1:0]   scene_frame_q, scene_frame_d;
  logic [FRAME_CNT_W-1:0]     frame_count_q, frame_count_d;
  logic                       in_transition_q, in_transition_d;

  logic               tick;
  logic [SCENE_W-1:0] scene_inc;
  logic               sel_valid;

  assign tick      = frame_tick & ~pause_s;
  assign scene_inc = (scene_id_q == LAST_SCENE) ? '0 : scene_id_q + SCENE_W'(1);
  assign sel_valid = ({1'b0, sel_s} < SCENE_LIM) && (sel_s != scene_id_q);

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FADE_IN;
      scene_id_q      <= '0;
      next_q          <= '0;
      fade_q          <= '0;
      scene_frame_q   <= '0;
      frame_count_q   <= '0;
      in_transition_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      scene_id_q      <= scene_id_d;
      next_q          <= next_d;
      fade_q          <= fade_d;
      scene_frame_q   <= scene_frame_d;
      frame_count_q   <= frame_count_d;
      in_transition_q <= in_transition_d;
    end
  end

  // Next-state and counter updates; a skip edge pre-empts the tick's fade and
  // scene_frame update but never the frame counter
  always_comb begin
    state_d       = state_q;
    scene_id_d    = scene_id_q;
    next_d        = next_q;
    fade_d        = fade_q;
    scene_frame_d = scene_frame_q;
    frame_count_d = frame_count_q;

    if (tick) begin
      frame_count_d = frame_count_q + FRAME_CNT_W'(1);
    end

    unique case (state_q)
      FADE_IN: begin
        if (skip_rise) begin
          state_d = FADE_OUT;
          next_d  = scene_inc;
        end else if (tick) begin
          if (fade_q == FADE_FULL) begin
            state_d       = SHOW;
            scene_frame_d = '0;
          end else begin
            fade_d = fade_q + FADE_W'(1);
          end
        end
      end
      SHOW: begin
        if (skip_rise) begin
          state_d = FADE_OUT;
          next_d  = scene_inc;
        end else if (tick) begin
          scene_frame_d = scene_frame_q + SCENE_FRAME_W'(1);
          if (sel_en_s) begin
            if (sel_valid) begin
              state_d = FADE_OUT;
              next_d  = sel_s;
            end
          end else if (scene_frame_q == LAST_FRAME) begin
            state_d = FADE_OUT;
            next_d  = scene_inc;
          end
        end
      end
      FADE_OUT: begin
        if (tick) begin
          if (fade_q == '0) begin
            state_d       = FADE_IN;
            scene_id_d    = next_q;
            scene_frame_d = '0;
          end else begin
            fade_d = fade_q - FADE_W'(1);
          end
        end
      end
      default: begin
        state_d = FADE_IN;
      end
    endcase

    in_transition_d = (state_d != SHOW);
  end

  assign scene_id      = scene_id_q;
  assign fade          = fade_q;
  assign scene_frame   = scene_frame_q;
  assign frame_count   = frame_count_q;
  assign in_transition = in_transition_q;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Self-checking bench for demo_scene_sequencer: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_demo_scene_sequencer;

  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int SF  = 4;
  localparam int FW  = 4;
  localparam int FMX = (1 << FW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          pause = 1'b0;
  logic          skip = 1'b0;
  logic          sel_en = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [SW-1:0] scene_id;
  logic [FW-1:0] fade;
  logic [9:0]    scene_frame;
  logic [15:0]   frame_count;
  logic          in_transition;

  int n_tests = 0;
  int n_fail  = 0;

  demo_scene_sequencer #(
    .NUM_SCENES(NS), .SCENE_W(SW), .SCENE_FRAMES(SF), .FADE_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .skip(skip), .sel_en(sel_en), .sel(sel), .scene_id(scene_id),
    .fade(fade), .scene_frame(scene_frame), .frame_count(frame_count),
    .in_transition(in_transition)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = brightening, 1 = showing, 2 = darkening
  int m_phase, m_fade, m_sf, m_fc, m_scene, m_next;
  // input history: [0] = one edge ago, [1] = two edges ago, [2] = three edges ago
  int hp[3], hs[3], he[3], hv[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_fade = 0; m_sf = 0; m_fc = 0; m_scene = 0; m_next = 0;
      for (int i = 0; i < 3; i++) begin hp[i] = 0; hs[i] = 0; he[i] = 0; hv[i] = 0; end
    end else begin
      bit p, sk, tk;
      p  = (hp[1] != 0);
      sk = (hs[1] != 0) && (hs[2] == 0);
      tk = frame_tick && !p;
      if (tk) m_fc = (m_fc + 1) % 65536;
      if (sk && m_phase != 2) begin
        m_phase = 2;
        m_next  = (m_scene + 1) % NS;
      end else if (tk) begin
        if (m_phase == 0) begin
          if (m_fade == FMX) begin m_phase = 1; m_sf = 0; end
          else m_fade = m_fade + 1;
        end else if (m_phase == 1) begin
          m_sf = (m_sf + 1) % 1024;
          if (he[1] != 0) begin
            if (hv[1] != m_scene && hv[1] < NS) begin m_next = hv[1]; m_phase = 2; end
          end else if (m_sf == SF) begin
            m_next = (m_scene + 1) % NS; m_phase = 2;
          end
        end else begin
          if (m_fade == 0) begin m_scene = m_next; m_sf = 0; m_phase = 0; end
          else m_fade = m_fade - 1;
        end
      end
      for (int i = 2; i > 0; i--) begin
        hp[i] = hp[i-1]; hs[i] = hs[i-1]; he[i] = he[i-1]; hv[i] = hv[i-1];
      end
      hp[0] = int'(pause); hs[0] = int'(skip); he[0] = int'(sel_en); hv[0] = int'(sel);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (int'(scene_id) != m_scene || int'(fade) != m_fade || int'(scene_frame) != m_sf ||
          int'(frame_count) != m_fc || in_transition != (m_phase != 1)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got scene=%0d fade=%0d sf=%0d fc=%0d tr=%0b, expected scene=%0d fade=%0d sf=%0d fc=%0d tr=%0b",
                 $time, scene_id, fade, scene_frame, frame_count, in_transition,
                 m_scene, m_fade, m_sf, m_fc, (m_phase != 1));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  // Scene-change monitor: records every new scene_id, fade must already be black
  bit mon_on = 1'b0;
  int scene_q[$];
  int prev_scene = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_scene = 0;
    else begin
      if (mon_on && int'(scene_id) != prev_scene) begin
        scene_q.push_back(int'(scene_id));
        check("fade_zero_at_scene_change", int'(fade), 0);
      end
      prev_scene = int'(scene_id);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_seq[4];
    int guard;
    exp_seq = '{1, 2, 3, 0};

    // Reset values
    cyc(3);
    check("rst_scene", int'(scene_id), 0);
    check("rst_fade", int'(fade), 0);
    check("rst_sf", int'(scene_frame), 0);
    check("rst_fc", int'(frame_count), 0);
    check("rst_trans", int'(in_transition), 1);
    rst_n = 1'b1;
    cyc(2);

    // Fade-in ramp: 1..15, then SHOW on the 16th tick
    for (int k = 1; k <= 16; k++) begin
      tick_once();
      check("fadein_level", int'(fade), (k < FMX) ? k : FMX);
    end
    check("fadein_show", int'(in_transition), 0);
    check("fadein_sf", int'(scene_frame), 0);
    check("fadein_fc", int'(frame_count), 16);

    // Skip coinciding with a tick at scene_frame=2
    tick_once();
    tick_once();
    check("pre_skip_sf", int'(scene_frame), 2);
    scene_q.delete();
    mon_on = 1'b1;
    skip = 1'b1;
    cyc(2);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check("skip_trans", int'(in_transition), 1);
    check("skip_fade", int'(fade), 15);
    check("skip_sf", int'(scene_frame), 2);
    check("skip_fc", int'(frame_count), 19);
    skip = 1'b0;
    cyc(1);

    // Run to scene wrap: expect 1,2,3,0
    guard = 0;
    while (scene_q.size() < 4 && guard < 400) begin tick_once(); guard++; end
    check("wrap_in_time", int'(guard < 400), 1);
    for (int i = 0; i < 4; i++)
      check("scene_seq", (scene_q.size() > i) ? scene_q[i] : -1, exp_seq[i]);
    mon_on = 1'b0;

    // Pause mid fade-in at fade=5
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    repeat (5) tick_once();
    check("pause_pre_fade", int'(fade), 5);
    pause = 1'b1;
    cyc(3);
    repeat (10) tick_once();
    check("pause_fade", int'(fade), 5);
    check("pause_fc", int'(frame_count), 5);
    check("pause_trans", int'(in_transition), 1);
    pause = 1'b0;
    cyc(3);
    tick_once();
    check("resume_fade", int'(fade), 6);
    check("resume_fc", int'(frame_count), 6);

    // Manual select scene 3 from SHOW of scene 0
    guard = 0;
    while (in_transition && guard < 30) begin tick_once(); guard++; end
    check("manual_show_reached", int'(in_transition), 0);
    sel = 2'd3;
    sel_en = 1'b1;
    cyc(3);
    scene_q.delete();
    mon_on = 1'b1;
    tick_once();
    check("manual_fadeout", int'(in_transition), 1);
    check("manual_fadeout_fade", int'(fade), 15);
    guard = 0;
    while (!(scene_id == 2'd3 && !in_transition) && guard < 80) begin tick_once(); guard++; end
    check("manual_scene3_show", int'(guard < 80), 1);
    repeat (10) tick_once();
    check("manual_hold_trans", int'(in_transition), 0);
    check("manual_hold_scene", int'(scene_id), 3);
    check("manual_hold_sf", int'(scene_frame), 10);
    check("manual_changes", scene_q.size(), 1);
    mon_on = 1'b0;

    // Move to scene 2, then start leaving it and reset at fade=7
    sel = 2'd2;
    cyc(3);
    guard = 0;
    while (!(scene_id == 2'd2 && !in_transition) && guard < 80) begin tick_once(); guard++; end
    check("scene2_show", int'(guard < 80), 1);
    sel = 2'd0;
    cyc(3);
    tick_once();
    repeat (8) tick_once();
    check("pre_reset_fade", int'(fade), 7);
    check("pre_reset_scene", int'(scene_id), 2);
    check("pre_reset_trans", int'(in_transition), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_scene", int'(scene_id), 0);
    check("async_rst_fade", int'(fade), 0);
    check("async_rst_sf", int'(scene_frame), 0);
    check("async_rst_fc", int'(frame_count), 0);
    check("async_rst_trans", int'(in_transition), 1);
    sel_en = 1'b0;
    sel = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      if ($urandom_range(0, 14) == 0) skip = ~skip;
      if ($urandom_range(0, 59) == 0) sel_en = ~sel_en;
      if ($urandom_range(0, 29) == 0) sel = SW'($urandom_range(0, NS - 1));
      rst_n = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    frame_tick = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
